// File: rtl/cdnsusbhs_sync_debounce.sv
// Debounce filter for one synchronized level in the rxclk domain.
// It drives a debounced level and one-cycle rise/fall pulses.
// A change is accepted only after N consecutive opposite samples.
// N is dbnc_len, and a value of 0 counts as 1.
// Optional feature: define CDNSUSBHS_DBNC_IRQ_EN to get a sticky edge status (irq_stat).
module cdnsusbhs_sync_debounce #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_rxclk,
  input  logic             i_rxrst,
  input  logic             i_rxsignal,
  input  logic [CNT_W-1:0] i_dbnc_len,
  output logic             o_dbnc_out,
  output logic             o_dbnc_rise,
  output logic             o_dbnc_fall,
  output logic             o_dbnc_pending,
  input  logic             i_irq_clr,
  output logic             o_irq_stat
);

  typedef enum logic [1:0] {
    ST_HI = 2'd0,
    PD_LO = 2'd1,
    ST_LO = 2'd2,
    PD_HI = 2'd3
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_pending;

  logic [CNT_W-1:0] w_n;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_done;

  // Effective threshold, plus the completion test for the sample being taken now.
  // r_cnt is 0 in the stable states, so w_done there reduces to N==1.
  // The increment is one bit wider so that it cannot wrap.
  always_comb begin
    w_n       = (i_dbnc_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : i_dbnc_len;
    w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_done    = (w_cnt_inc >= {1'b0, w_n});
  end

  // Filter FSM; the level, the pulses and the pending flag are all registered.
  always_ff @(posedge i_rxclk) begin
    if (i_rxrst) begin
      r_state   <= ST_HI;
      r_cnt     <= '0;
      r_out     <= 1'b1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        ST_HI: begin
          if (!i_rxsignal) begin
            if (w_done) begin
              r_state <= ST_LO;
              r_out   <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_state   <= PD_LO;
              r_cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_pending <= 1'b1;
            end
          end
        end
        PD_LO: begin
          if (i_rxsignal) begin
            r_state   <= ST_HI;
            r_cnt     <= '0;
            r_pending <= 1'b0;
          end else if (w_done) begin
            r_state   <= ST_LO;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_fall    <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        ST_LO: begin
          if (i_rxsignal) begin
            if (w_done) begin
              r_state <= ST_HI;
              r_out   <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_state   <= PD_HI;
              r_cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_pending <= 1'b1;
            end
          end
        end
        PD_HI: begin
          if (!i_rxsignal) begin
            r_state   <= ST_LO;
            r_cnt     <= '0;
            r_pending <= 1'b0;
          end else if (w_done) begin
            r_state   <= ST_HI;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_out     <= 1'b1;
            r_rise    <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          r_state   <= ST_HI;
          r_cnt     <= '0;
          r_out     <= 1'b1;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign o_dbnc_out     = r_out;
  assign o_dbnc_rise    = r_rise;
  assign o_dbnc_fall    = r_fall;
  assign o_dbnc_pending = r_pending;

`ifdef CDNSUSBHS_DBNC_IRQ_EN
  logic r_irq;

  // Sticky edge status; a set event in the same cycle as a clear takes priority.
  always_ff @(posedge i_rxclk) begin
    if (i_rxrst) begin
      r_irq <= 1'b0;
    end else if (r_rise || r_fall) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq_stat = r_irq;
`else
  logic w_unused_irq_clr;
  assign w_unused_irq_clr = i_irq_clr;
  assign o_irq_stat       = 1'b0;
`endif

endmodule

// File: tb/tb_cdnsusbhs_sync_debounce.sv
// Self-checking bench for cdnsusbhs_sync_debounce.
// Each drive step runs a run-length reference model and pushes the expected outputs to a queue.
// The entry is popped and compared just after the clock edge that produces them.
// Define CDNSUSBHS_DBNC_IRQ_EN to check the sticky irq_stat; otherwise it must read 0.
module tb_cdnsusbhs_sync_debounce;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig;
  logic [CNT_W-1:0] len;
  logic             irq_clr;
  logic             dbnc_out, dbnc_rise, dbnc_fall, dbnc_pending, irq_stat;

  typedef struct packed {
    logic out;
    logic rise;
    logic fall;
    logic pend;
    logic irq;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: the accepted level and the run of consecutive opposite samples.
  logic m_lvl  = 1'b1;
  int   m_run  = 0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  logic m_irq  = 1'b0;

  cdnsusbhs_sync_debounce #(
    .CNT_W (CNT_W)
  ) u_dut (
    .i_rxclk        (clk),
    .i_rxrst        (rst),
    .i_rxsignal     (sig),
    .i_dbnc_len     (len),
    .o_dbnc_out     (dbnc_out),
    .o_dbnc_rise    (dbnc_rise),
    .o_dbnc_fall    (dbnc_fall),
    .o_dbnc_pending (dbnc_pending),
    .i_irq_clr      (irq_clr),
    .o_irq_stat     (irq_stat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one sampling edge.
  task automatic model_step(input logic s, input logic [CNT_W-1:0] l, input logic c,
                            input logic r);
    int n;
    exp_t e;
    n = (l == 0) ? 1 : int'(l);
    if (r) begin
      m_lvl = 1'b1; m_run = 0; m_rise = 1'b0; m_fall = 1'b0; m_irq = 1'b0;
    end else begin
`ifdef CDNSUSBHS_DBNC_IRQ_EN
      if (m_rise || m_fall) m_irq = 1'b1;
      else if (c)           m_irq = 1'b0;
`else
      m_irq = 1'b0;
`endif
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run >= n) begin
          m_lvl = s;
          m_run = 0;
          if (s) m_rise = 1'b1;
          else   m_fall = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    e.out  = m_lvl;
    e.rise = m_rise;
    e.fall = m_fall;
    e.pend = (m_run != 0);
    e.irq  = m_irq;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, queue the expectation, then compare after the edge.
  task automatic step(input logic s, input logic [CNT_W-1:0] l, input logic c = 1'b0,
                      input logic r = 1'b0);
    exp_t e;
    sig = s; len = l; irq_clr = c; rst = r;
    model_step(s, l, c, r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("dbnc_out",     {31'd0, dbnc_out},     {31'd0, e.out});
      check_eq("dbnc_rise",    {31'd0, dbnc_rise},    {31'd0, e.rise});
      check_eq("dbnc_fall",    {31'd0, dbnc_fall},    {31'd0, e.fall});
      check_eq("dbnc_pending", {31'd0, dbnc_pending}, {31'd0, e.pend});
      check_eq("irq_stat",     {31'd0, irq_stat},     {31'd0, e.irq});
      check_eq("rise_fall_excl", {31'd0, dbnc_rise & dbnc_fall}, 32'd0);
    end
  endtask

  task automatic hold(input logic s, input logic [CNT_W-1:0] l, input int cycles);
    for (int i = 0; i < cycles; i++) step(s, l);
  endtask

  int glitch_len[3] = '{3, 1, 2};

  initial begin
    // Reset, then a stable high input.
    for (int i = 0; i < 3; i++) step(1'b1, 16'd4, 1'b0, 1'b1);
    hold(1'b1, 16'd4, 20);

    // Full fall after four low samples, then a full rise.
    hold(1'b0, 16'd4, 6);
    hold(1'b1, 16'd4, 6);

    // Glitches shorter than the threshold are rejected.
    foreach (glitch_len[g]) begin
      hold(1'b0, 16'd4, glitch_len[g]);
      hold(1'b1, 16'd4, 5);
    end

    // N of 0 and 1: follow the input with one edge of delay, including a toggle every cycle.
    for (int i = 0; i < 8; i++) step(i[0] ? 1'b1 : 1'b0, 16'd0);
    hold(1'b1, 16'd0, 2);
    for (int i = 0; i < 8; i++) step(i[0] ? 1'b1 : 1'b0, 16'd1);
    hold(1'b1, 16'd1, 2);

    // Shrinking the length mid-count completes the change on the next opposite sample.
    hold(1'b0, 16'd10, 5);
    hold(1'b0, 16'd3, 3);
    hold(1'b1, 16'd10, 12);

    // Reset mid-count abandons the count; a full count is needed afterwards.
    hold(1'b0, 16'd10, 5);
    step(1'b0, 16'd10, 1'b0, 1'b1);
    hold(1'b0, 16'd10, 12);

    // Sticky status: clear, an event, then a clear in the same cycle as a visible rise.
    step(1'b0, 16'd1, 1'b1);
    step(1'b0, 16'd1);
    step(1'b1, 16'd1);
    step(1'b1, 16'd1, 1'b1);
    step(1'b1, 16'd1);
    step(1'b1, 16'd1, 1'b1);
    hold(1'b1, 16'd1, 3);

    if (exp_q.size() != 0) check_eq("queue_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cdnsusbhs_sync_debounce.md
Name: cdnsusbhs_sync_debounce

Overview:
- Sits directly downstream of the 2-flop single-bit synchronizer, in the same rxclk domain.
- Consumes the synchronized level, which resets to 1, and removes glitches with a programmable stable-count filter.
- Produces a debounced level plus one-cycle rise and fall pulses for OTG line-state/VBUS/ID consumers.

Parameters:
- CNT_W, 16, width of the debounce counter and of dbnc_len.

Ports:
- rxclk  input  1  block clock.
- rxrst  input  1  reset; synchronous, active-high.
- rxsignal  input  1  synchronized level from the upstream synchronizer.
- dbnc_len  input  CNT_W  required count of consecutive opposite samples, N; 0 is treated as 1.
- dbnc_out  output  1  debounced level.
- dbnc_rise  output  1  one-cycle pulse when dbnc_out goes 0->1.
- dbnc_fall  output  1  one-cycle pulse when dbnc_out goes 1->0.
- dbnc_pending  output  1  high while a candidate change is being counted.
- irq_clr  input  1  clears irq_stat (optional feature).
- irq_stat  output  1  sticky edge status (optional feature).

Behaviour:
- Clock and reset: one clock, rxclk; reset rxrst is synchronous and active-high.
- Reset values: dbnc_out=1, dbnc_rise=0, dbnc_fall=0, dbnc_pending=0, irq_stat=0, counter=0, state=ST_HI.
- Reset asserted mid-operation abandons any pending count. No pulse is generated by reset.
- States: ST_HI, PD_LO, ST_LO, PD_HI. dbnc_out=1 in ST_HI/PD_LO, 0 in ST_LO/PD_HI. dbnc_pending=1 in PD_LO/PD_HI.
- Let N = (dbnc_len==0) ? 1 : dbnc_len. N is evaluated every cycle, so a live change takes effect immediately.
- ST_HI, rxsignal=1: hold.
- ST_HI, rxsignal=0: if N==1, go to ST_LO; otherwise go to PD_LO with cnt=1.
- PD_LO, rxsignal=1: glitch rejected; go to ST_HI, cnt=0, no pulse.
- PD_LO, rxsignal=0: if cnt+1 >= N, go to ST_LO and cnt=0; else cnt=cnt+1.
  - Using >= means shrinking dbnc_len mid-count completes the change on the next opposite sample.
- ST_LO/PD_HI: mirror image of the ST_HI/PD_LO rules.
- Latency: dbnc_out changes on the clock edge that samples the N-th consecutive opposite value. With N=1 this is the same edge as the first sample, i.e. one register stage after rxsignal.
- Counter arithmetic: cnt+1 is computed CNT_W+1 bits wide and cnt never wraps. At dbnc_len = 2^CNT_W-1, cnt reaches at most N-1.
- Pulses: dbnc_fall (dbnc_rise) is registered and asserts in the same cycle dbnc_out first shows 0 (1), for exactly one cycle. Rise and fall are never high together.
  - Back-to-back opposite transitions with N=1 give alternate single-cycle pulses on consecutive cycles.
- Stable input: dbnc_pending stays low and no pulses occur.

Optional Feature:
- Macro: CDNSUSBHS_DBNC_IRQ_EN.
- When defined:
  - irq_stat sets on any cycle dbnc_rise or dbnc_fall is high.
  - irq_stat stays set until irq_clr is sampled high.
  - If a set event and irq_clr occur in the same cycle, set wins and irq_stat stays 1.
  - Reset value 0.
- When undefined: irq_stat is tied to 0 and irq_clr is ignored. Both ports remain present in either build.

Test Plan:
- Reset with rxsignal=1, dbnc_len=4; release -> dbnc_out=1, no pulses, dbnc_pending=0 for 20 cycles.
- dbnc_len=4, drive rxsignal 1->0 and hold -> dbnc_pending high for 3 cycles, then on the 4th 0-sample dbnc_out=0 and dbnc_fall high for exactly 1 cycle.
  - Then drive 0->1 and hold -> dbnc_rise after 4 samples.
- dbnc_len=4, glitch rxsignal low for 3 cycles then high -> dbnc_out stays 1, no pulse, pending clears the cycle after the 1 is sampled.
  - Repeat with pulse lengths 1 and 2.
- dbnc_len=0 and dbnc_len=1 -> dbnc_out follows rxsignal with one edge of delay.
  - Toggling rxsignal every cycle gives alternating single-cycle rise/fall pulses, never both high together.
- dbnc_len=10, hold rxsignal=0 for 5 samples, then set dbnc_len=3 -> dbnc_out falls on the next 0-sample.
  - Separately: assert rxrst mid-count -> dbnc_out=1, pending=0, no pulse. After release with rxsignal still 0, a full 10-sample count is required.
- With CDNSUSBHS_DBNC_IRQ_EN defined:
  - Fall event -> irq_stat=1 and held.
  - irq_clr pulse -> irq_stat=0 next cycle.
  - irq_clr in the same cycle as dbnc_rise -> irq_stat remains 1.
- With CDNSUSBHS_DBNC_IRQ_EN undefined: irq_stat constant 0 in all of the above.
